// File: rtl/gcd_job_scheduler.sv
// gcd_job_scheduler: round-robin arbiter plus sequencer sharing one GCD subtract/swap datapath.
// Optional iteration limit and abort pulse: define ITER_LIMIT_EN.
`default_nettype none

module gcd_job_scheduler #(
    parameter int NREQ     = 4,
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic             endflag,
    input  logic             swapflag,
    output logic [NREQ-1:0]  gnt,
    output logic [4:0]       controlarr,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             err
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [4:0] CTRL_IDLE = 5'b00000;
    localparam logic [4:0] CTRL_LOAD = 5'b11100;
    localparam logic [4:0] CTRL_SWAP = 5'b11010;
    localparam logic [4:0] CTRL_SUB  = 5'b01001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_SWAP  = 3'd3,
        S_SUB   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   iter_q, iter_d;
    logic [NREQ-1:0]    win_oh;
    logic [PTR_W-1:0]   next_ptr;
    logic [CNT_W-1:0]   iter_inc;
    logic               req_lost;
`ifdef ITER_LIMIT_EN
    logic               err_q, err_d;
`endif

    // First set request at or after the round-robin pointer, wrapping upward.
    always_comb begin
        logic found;
        int   idx;
        win_oh = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                win_oh[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        next_ptr = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_q[k]) begin
                next_ptr = PTR_W'((k + 1) % NREQ);
            end
        end
    end

    assign req_lost = ~|(req & gnt_q);
    assign iter_inc = (&iter_q) ? iter_q : iter_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        iter_d     = iter_q;
        controlarr = CTRL_IDLE;
        done       = 1'b0;
`ifdef ITER_LIMIT_EN
        err_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_LOAD;
                    gnt_d   = win_oh;
                    iter_d  = '0;
                end
            end
            S_LOAD: begin
                controlarr = CTRL_LOAD;
                state_d    = S_CHECK;
            end
            S_CHECK: begin
                if (endflag) begin
                    state_d = S_DONE;
`ifdef ITER_LIMIT_EN
                end else if (iter_q == CNT_W'(MAX_ITER)) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    rr_d    = next_ptr;
                    err_d   = 1'b1;
`endif
                end else if (swapflag) begin
                    state_d = S_SWAP;
                end else begin
                    state_d = S_SUB;
                end
            end
            S_SWAP: begin
                controlarr = CTRL_SWAP;
                iter_d     = iter_inc;
                state_d    = S_CHECK;
            end
            S_SUB: begin
                controlarr = CTRL_SUB;
                iter_d     = iter_inc;
                state_d    = S_CHECK;
            end
            S_DONE: begin
                done    = 1'b1;
                gnt_d   = '0;
                rr_d    = next_ptr;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase

        // A requester withdrawing mid-job aborts it silently; this overrides the step decision.
        if ((state_q == S_LOAD || state_q == S_CHECK ||
             state_q == S_SWAP || state_q == S_SUB) && req_lost) begin
            state_d = S_IDLE;
            gnt_d   = '0;
            rr_d    = next_ptr;
            iter_d  = iter_q;
`ifdef ITER_LIMIT_EN
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            iter_q  <= '0;
`ifdef ITER_LIMIT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            iter_q  <= iter_d;
`ifdef ITER_LIMIT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign busy     = (state_q != S_IDLE);
    assign iter_cnt = iter_q;
`ifdef ITER_LIMIT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gcd_job_scheduler.sv
// tb_gcd_job_scheduler: directed bench with a behavioural X/Y GCD datapath driven by controlarr.
`default_nettype none

module tb_gcd_job_scheduler;

    localparam int NREQ  = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NREQ-1:0]  req = '0;
    logic             endflag, swapflag;
    logic [NREQ-1:0]  gnt;
    logic [4:0]       controlarr;
    logic             done, busy, err;
    logic [CNT_W-1:0] iter_cnt;

    logic [15:0] x_q = '0, y_q = '0;
    logic [15:0] op_a [NREQ];
    logic [15:0] op_b [NREQ];
    logic [15:0] sel_a, sel_b;

    int n_checks = 0;
    int n_fail   = 0;

    gcd_job_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W), .MAX_ITER(3)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .endflag    (endflag),
        .swapflag   (swapflag),
        .gnt        (gnt),
        .controlarr (controlarr),
        .done       (done),
        .busy       (busy),
        .iter_cnt   (iter_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                sel_a = op_a[k];
                sel_b = op_b[k];
            end
        end
    end

    always @(posedge clk) begin
        if (controlarr[2]) begin
            x_q <= sel_a;
            y_q <= sel_b;
        end else if (controlarr[1]) begin
            x_q <= y_q;
            y_q <= x_q;
        end else if (controlarr[0]) begin
            x_q <= x_q - y_q;
        end
    end

    assign endflag  = (y_q == 16'd0);
    assign swapflag = (x_q < y_q);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_end(input int budget, output bit got_done, output bit got_err);
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (err) begin
                got_err = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_grant(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gnt != '0) break;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [NREQ-1:0] exp_gnt [4];
    logic [15:0]     exp_x   [4];
    bit d, e;

    initial begin
        for (int k = 0; k < NREQ; k++) begin
            op_a[k] = '0;
            op_b[k] = '0;
        end
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_x   = '{16'd4, 16'd5, 16'd7, 16'd3};

        do_reset();
        check("rst_gnt",  gnt, 0);
        check("rst_ctrl", controlarr, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_iter", iter_cnt, 0);
        check("rst_err",  err, 0);

        // 48,18: sub,sub,swap,sub,swap,sub,sub,swap -> X=6 after 8 steps
        op_a[0] = 16'd48; op_b[0] = 16'd18;
        req = 4'b0001;
        @(negedge clk);
        check("t1_gnt",  gnt, 4'b0001);
        check("t1_load", controlarr, 5'b11100);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_check_ctrl", controlarr, 5'b00000);
        @(negedge clk);
        check("t1_first_sub", controlarr, 5'b01001);
        wait_end(100, d, e);
        check("t1_done", d, 1);
        check("t1_x", x_q, 6);
        check("t1_iter", iter_cnt, 8);
        check("t1_gnt_held", gnt, 4'b0001);
        req = '0;
        @(negedge clk);
        check("t1_gnt_clr", gnt, 0);
        check("t1_idle", busy, 0);
        check("t1_done_pulse", done, 0);
        check("t1_iter_hold", iter_cnt, 8);

        // four held requests served in round-robin order from pointer 0
        do_reset();
        op_a[0] = 16'd12; op_b[0] = 16'd8;
        op_a[1] = 16'd15; op_b[1] = 16'd10;
        op_a[2] = 16'd21; op_b[2] = 16'd14;
        op_a[3] = 16'd9;  op_b[3] = 16'd6;
        req = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            wait_grant(5);
            check($sformatf("t2_gnt%0d", j), gnt, exp_gnt[j]);
            wait_end(200, d, e);
            check($sformatf("t2_done%0d", j), d, 1);
            check($sformatf("t2_x%0d", j), x_q, exp_x[j]);
            if (j == 3) req = '0;
        end

        // job on index 2 moves the pointer to 3; 0110 then wraps to index 1
        op_a[2] = 16'd8; op_b[2] = 16'd4;
        op_a[1] = 16'd0; op_b[1] = 16'd9;
        req = 4'b0100;
        wait_grant(5);
        check("t3_gnt_a", gnt, 4'b0100);
        wait_end(100, d, e);
        check("t3_done_a", d, 1);
        req = 4'b0110;
        wait_grant(5);
        check("t3_gnt_b", gnt, 4'b0010);
        // operands 0,9: one swap then endflag
        wait_end(100, d, e);
        req = '0;
        check("t4_done", d, 1);
        check("t4_x", x_q, 9);
        check("t4_iter", iter_cnt, 1);

        // operands 9,0: endflag at first CHECK, done on the following cycle
        op_a[1] = 16'd9; op_b[1] = 16'd0;
        req = 4'b0010;
        wait_grant(5);
        check("t4b_gnt", gnt, 4'b0010);
        @(negedge clk);
        check("t4b_check_nodone", done, 0);
        @(negedge clk);
        check("t4b_done", done, 1);
        check("t4b_iter", iter_cnt, 0);
        check("t4b_x", x_q, 9);
        req = '0;
        @(negedge clk);

        // reset while in SUB
        op_a[0] = 16'd48; op_b[0] = 16'd18;
        req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (controlarr == 5'b01001) break;
        end
        check("t5_in_sub", controlarr, 5'b01001);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_gnt",  gnt, 0);
        check("t5_rst_ctrl", controlarr, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_iter", iter_cnt, 0);
        check("t5_rst_done", done, 0);
        reset = 1'b0;
        req   = '0;
        @(negedge clk);

        // withdraw request during CHECK
        req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        check("t5w_in_check", busy, 1);
        req = '0;
        @(negedge clk);
        check("t5w_gnt", gnt, 0);
        check("t5w_busy", busy, 0);
        check("t5w_done", done, 0);
        wait_end(6, d, e);
        check("t5w_no_done", d, 0);

        // long job 1000,1
        op_a[0] = 16'd1000; op_b[0] = 16'd1;
        req = 4'b0001;
        wait_end(3000, d, e);
        req = '0;
`ifdef ITER_LIMIT_EN
        check("t6_err",  e, 1);
        check("t6_done", d, 0);
        check("t6_iter", iter_cnt, 3);
        check("t6_gnt",  gnt, 0);
`else
        check("t6_done", d, 1);
        check("t6_err",  err, 0);
        check("t6_x",    x_q, 1);
        check("t6_iter", iter_cnt, 1001);
`endif
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
